// File: rtl/des_round_ctrl.sv
// Sequences one DES block: load strobe, 16 round enables with key-shift control, final-permutation strobe.
// Latency: 18 cycles from the edge that samples start to dat_valid high; all outputs registered.
// Backpressure: with OUT_HOLD=1 dat_valid and busy hold until out_ready; with OUT_HOLD=0 dat_valid is a 1-cycle pulse.
module des_round_ctrl #(
   parameter bit OUT_HOLD = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       decrypt,
   input  logic       out_ready,
   output logic       busy,
   output logic       load_en,
   output logic       round_en,
   output logic [3:0] round_idx,
   output logic [1:0] shift_amt,
   output logic       shift_right,
   output logic       final_en,
   output logic       dat_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ROUND,
      S_FINAL,
      S_DONE
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [3:0] cnt_q;
   logic [3:0] cnt_d;
   logic       dir_q;
   logic       dir_d;
   logic [1:0] shift_d;

   // State, round counter and latched direction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   // Next-state logic; start is only looked at in IDLE, so requests while busy are dropped.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               dir_d   = decrypt;
               cnt_d   = 4'd0;
            end
         end
         S_LOAD: begin
            state_d = S_ROUND;
            cnt_d   = 4'd0;
         end
         S_ROUND: begin
            if (cnt_q == 4'd15) begin
               state_d = S_FINAL;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_FINAL: begin
            state_d = S_DONE;
         end
         S_DONE: begin
            if (!OUT_HOLD || out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Key-schedule rotate amount for the round about to run. Decrypt skips the
   // first rotate so the right rotations undo the encrypt schedule in reverse.
   always_comb begin
      shift_d = 2'd2;
      case (cnt_d)
         4'd0:                shift_d = dir_q ? 2'd0 : 2'd1;
         4'd1, 4'd8, 4'd15:   shift_d = 2'd1;
         default:             shift_d = 2'd2;
      endcase
   end

   // Outputs registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy        <= 1'b0;
         load_en     <= 1'b0;
         round_en    <= 1'b0;
         round_idx   <= 4'd0;
         shift_amt   <= 2'd0;
         shift_right <= 1'b0;
         final_en    <= 1'b0;
         dat_valid   <= 1'b0;
      end else begin
         busy        <= (state_d != S_IDLE);
         load_en     <= (state_d == S_LOAD);
         round_en    <= (state_d == S_ROUND);
         round_idx   <= (state_d == S_ROUND) ? cnt_d : 4'd0;
         shift_amt   <= (state_d == S_ROUND) ? shift_d : 2'd0;
         shift_right <= (state_d == S_ROUND) && dir_q;
         final_en    <= (state_d == S_FINAL);
         dat_valid   <= (state_d == S_DONE);
      end
   end

endmodule
